// File: rtl/pheap_ctrl.sv
// Host-facing controller for the pipelined priority heap: accepts LEQ/DEQ requests,
// walks the operation down the levels one at a time and retires it with a one-cycle response.
package pheap_pkg;
  typedef enum logic {LEQ = 1'b0, DEQ = 1'b1} opcode_t;
  typedef enum logic [1:0] {WAIT = 2'b00, DONE = 2'b01, NEXT_LEVEL = 2'b10} done_t;
endpackage

module pheap_ctrl
  import pheap_pkg::*;
#(
  parameter int unsigned LEVELS = 4,
  parameter int unsigned PW     = LEVELS - 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  opcode_t                    req_op,
  input  logic [31:0]                req_value,
  output logic                       resp_valid,
  output logic [31:0]                resp_value,
  output logic                       resp_err,
  output logic [LEVELS:0]            count,
  output logic [LEVELS-1:0]          lvl_start,
  output opcode_t                    lvl_op,
  output logic [31:0]                lvl_in,
  output logic [PW-1:0]              lvl_pos,
  input  logic [2*LEVELS-1:0]        lvl_done,
  input  logic [LEVELS*LEVELS-1:0]   lvl_endpos,
  input  logic [32*LEVELS-1:0]       lvl_out
);

  localparam int unsigned CW = $clog2(LEVELS + 1);
  localparam logic [LEVELS:0] FULL = {(LEVELS+1){1'b1}} >> 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_SAMPLE, S_RESP} state_t;

  state_t          r_state, w_state_n;
  logic [CW-1:0]   r_cur;
  opcode_t         r_op;
  logic [31:0]     r_val;
  logic [PW-1:0]   r_pos;
  logic [31:0]     r_res;
  logic            r_err;
  logic [LEVELS:0] r_count;

  done_t           w_done;
  logic [31:0]     w_out;
  logic [PW-1:0]   w_ep;
  logic            w_reject;
  logic            w_unused;

  assign w_unused = ^lvl_endpos;

  // Select the current level's fields; only the low cur bits of its endPos are meaningful.
  always_comb begin
    w_done = WAIT;
    w_out  = '0;
    w_ep   = '0;
    for (int unsigned k = 0; k < LEVELS; k++) begin
      if (r_cur == CW'(k + 1)) begin
        w_done = done_t'(lvl_done[2*k +: 2]);
        w_out  = lvl_out[32*k +: 32];
        for (int unsigned j = 0; j < PW; j++) begin
          if (j <= k) w_ep[j] = lvl_endpos[LEVELS*k + j];
        end
      end
    end
  end

  assign w_reject = ((req_op == LEQ) && (r_count == FULL)) ||
                    ((req_op == DEQ) && (r_count == '0));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:   if (req_valid) w_state_n = w_reject ? S_RESP : S_START;
      S_START:  w_state_n = S_SAMPLE;
      S_SAMPLE: begin
        case (w_done)
          DONE:       w_state_n = S_RESP;
          NEXT_LEVEL: w_state_n = (r_cur == CW'(LEVELS)) ? S_RESP : S_START;
          default:    w_state_n = S_SAMPLE;
        endcase
      end
      S_RESP:   w_state_n = S_IDLE;
      default:  w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur   <= '0;
      r_op    <= LEQ;
      r_val   <= '0;
      r_pos   <= '0;
      r_res   <= '0;
      r_err   <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_res <= '0;
          if (w_reject) begin
            r_err <= 1'b1;
          end else begin
            r_op  <= req_op;
            r_val <= req_value;
            r_pos <= '0;
            r_cur <= CW'(1);
            r_err <= 1'b0;
          end
        end
        S_SAMPLE: begin
          // DEQ result is the root value, captured whenever level 1 finishes its step.
          if ((r_op == DEQ) && (r_cur == CW'(1)) && (w_done == DONE || w_done == NEXT_LEVEL))
            r_res <= w_out;
          if (w_done == NEXT_LEVEL) begin
            if (r_cur == CW'(LEVELS)) begin
              r_err <= 1'b1;
            end else begin
              r_pos <= w_ep;
              if (r_op == LEQ) r_val <= w_out;
              r_cur <= r_cur + CW'(1);
            end
          end
        end
        S_RESP: if (!r_err) begin
          if (r_op == LEQ) r_count <= r_count + (LEVELS+1)'(1);
          else             r_count <= r_count - (LEVELS+1)'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    lvl_start = '0;
    for (int unsigned k = 0; k < LEVELS; k++)
      lvl_start[k] = (r_state == S_START) && (r_cur == CW'(k + 1));
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_err   = (r_state == S_RESP) && r_err;
  assign resp_value = ((r_state == S_RESP) && !r_err) ? r_res : '0;
  assign count      = r_count;
  assign lvl_op     = r_op;
  assign lvl_in     = r_val;
  assign lvl_pos    = r_pos;

endmodule

// File: tb/tb_pheap_ctrl.sv
// Bench for pheap_ctrl: scripted level stubs, start/response scoreboards with cycle-accurate expectations.
module tb_pheap_ctrl;
  import pheap_pkg::*;

  localparam int unsigned LEVELS = 4;
  localparam int unsigned PW     = LEVELS - 1;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     req_valid = 1'b0;
  logic                     req_ready;
  opcode_t                  req_op = LEQ;
  logic [31:0]              req_value = '0;
  logic                     resp_valid;
  logic [31:0]              resp_value;
  logic                     resp_err;
  logic [LEVELS:0]          count;
  logic [LEVELS-1:0]        lvl_start;
  opcode_t                  lvl_op;
  logic [31:0]              lvl_in;
  logic [PW-1:0]            lvl_pos;
  logic [2*LEVELS-1:0]      lvl_done;
  logic [LEVELS*LEVELS-1:0] lvl_endpos;
  logic [32*LEVELS-1:0]     lvl_out;

  pheap_ctrl #(.LEVELS(LEVELS), .PW(PW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_value(req_value), .resp_valid(resp_valid),
    .resp_value(resp_value), .resp_err(resp_err), .count(count),
    .lvl_start(lvl_start), .lvl_op(lvl_op), .lvl_in(lvl_in), .lvl_pos(lvl_pos),
    .lvl_done(lvl_done), .lvl_endpos(lvl_endpos), .lvl_out(lvl_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Level stubs: after a start, present WAIT for cfg_wait cycles, then cfg_code.
  int unsigned       cfg_wait [LEVELS];
  done_t             cfg_code [LEVELS];
  logic [31:0]       cfg_out  [LEVELS];
  logic [LEVELS-1:0] cfg_ep   [LEVELS];
  logic              act      [LEVELS];
  int unsigned       cnt      [LEVELS];

  always @(posedge clk) begin
    for (int k = 0; k < LEVELS; k++) begin
      if (rst || resp_valid) act[k] <= 1'b0;
      else if (lvl_start[k]) begin act[k] <= 1'b1; cnt[k] <= 0; end
      else if (act[k]) cnt[k] <= cnt[k] + 1;
    end
  end

  always_comb begin
    lvl_done   = '0;
    lvl_endpos = '0;
    lvl_out    = '0;
    for (int k = 0; k < LEVELS; k++) begin
      lvl_done[2*k +: 2]        = (act[k] && cnt[k] >= cfg_wait[k]) ? cfg_code[k] : WAIT;
      lvl_endpos[LEVELS*k +: LEVELS] = cfg_ep[k];
      lvl_out[32*k +: 32]       = cfg_out[k];
    end
  end

  typedef struct { int cy; int k; opcode_t op; logic [31:0] in; logic [PW-1:0] pos; } start_t;
  typedef struct { int cy; logic [31:0] val; logic err; } resp_t;
  start_t start_q[$];
  resp_t  resp_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (lvl_start != '0) begin
        if (start_q.size() == 0) check("unexp_start", 64'(lvl_start), 64'd0);
        else begin
          start_t s;
          s = start_q.pop_front();
          check("start_cyc", 64'(cyc), 64'(s.cy));
          check("start_vec", 64'(lvl_start), 64'(1 << (s.k - 1)));
          check("start_op",  64'(lvl_op), 64'(s.op));
          check("start_in",  64'(lvl_in), 64'(s.in));
          check("start_pos", 64'(lvl_pos), 64'(s.pos));
        end
      end
      if (resp_valid) begin
        if (resp_q.size() == 0) check("unexp_resp", 64'(resp_valid), 64'd0);
        else begin
          resp_t r;
          r = resp_q.pop_front();
          check("resp_cyc", 64'(cyc), 64'(r.cy));
          check("resp_val", 64'(resp_value), 64'(r.val));
          check("resp_err", 64'(resp_err), 64'(r.err));
        end
      end
    end
  end

  task automatic cfg(input int k, input int unsigned w, input done_t c,
                     input logic [31:0] o, input logic [LEVELS-1:0] ep);
    cfg_wait[k-1] = w; cfg_code[k-1] = c; cfg_out[k-1] = o; cfg_ep[k-1] = ep;
  endtask

  task automatic cfg_clear();
    for (int k = 1; k <= LEVELS; k++) cfg(k, 0, WAIT, '0, '0);
  endtask

  task automatic exp_start(input int cy, input int k, input opcode_t op,
                           input logic [31:0] in, input logic [PW-1:0] pos);
    start_t s;
    s.cy = cy; s.k = k; s.op = op; s.in = in; s.pos = pos;
    start_q.push_back(s);
  endtask

  task automatic exp_resp(input int cy, input logic [31:0] val, input logic err);
    resp_t r;
    r.cy = cy; r.val = val; r.err = err;
    resp_q.push_back(r);
  endtask

  // Called at a negedge while idle; accepted at the following posedge.
  task automatic issue(input opcode_t op, input logic [31:0] v);
    check("ready_idle", 64'(req_ready), 64'd1);
    req_op = op; req_value = v; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input logic [LEVELS:0] exp_count);
    int i;
    for (i = 0; i < 60 && resp_q.size() > 0; i++) begin
      @(negedge clk); #1;
    end
    if (resp_q.size() > 0) begin
      check("resp_timeout", 64'(resp_q.size()), 64'd0);
      resp_q.delete();
    end
    @(negedge clk);
    check("count", 64'(count), 64'(exp_count));
  endtask

  int c0;

  initial begin
    cfg_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_rvalid", 64'(resp_valid), 64'd0);
    check("rst_rvalue", 64'(resp_value), 64'd0);
    check("rst_rerr", 64'(resp_err), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_start", 64'(lvl_start), 64'd0);
    check("rst_in", 64'(lvl_in), 64'd0);
    check("rst_pos", 64'(lvl_pos), 64'd0);
    check("rst_op", 64'(lvl_op), 64'(LEQ));

    // DEQ on empty heap
    c0 = cyc; exp_resp(c0 + 1, 32'd0, 1'b1);
    issue(DEQ, 32'h1234);
    wait_resp(0);

    // LEQ 5, level 1 done
    cfg_clear(); cfg(1, 0, DONE, 32'd0, '0);
    c0 = cyc; exp_start(c0 + 1, 1, LEQ, 32'd5, '0); exp_resp(c0 + 3, 32'd0, 1'b0);
    issue(LEQ, 32'd5);
    @(negedge clk); check("busy_ready", 64'(req_ready), 64'd0);
    wait_resp(1);

    // LEQ 7, displaced 3 moves to level 2 at pos 1
    cfg_clear(); cfg(1, 0, NEXT_LEVEL, 32'd3, 4'b1011); cfg(2, 0, DONE, 32'd0, '0);
    c0 = cyc;
    exp_start(c0 + 1, 1, LEQ, 32'd7, 3'd0); exp_start(c0 + 3, 2, LEQ, 32'd3, 3'd1);
    exp_resp(c0 + 5, 32'd0, 1'b0);
    issue(LEQ, 32'd7);
    wait_resp(2);

    // DEQ returns root 9; value broadcast unchanged at level 2
    cfg_clear(); cfg(1, 0, NEXT_LEVEL, 32'd9, 4'b0000); cfg(2, 0, DONE, 32'd77, '0);
    c0 = cyc;
    exp_start(c0 + 1, 1, DEQ, 32'hABCD, 3'd0); exp_start(c0 + 3, 2, DEQ, 32'hABCD, 3'd0);
    exp_resp(c0 + 5, 32'd9, 1'b0);
    issue(DEQ, 32'hABCD);
    wait_resp(1);

    // Two WAIT cycles on level 1, single start pulse
    cfg_clear(); cfg(1, 2, DONE, 32'd0, '0);
    c0 = cyc; exp_start(c0 + 1, 1, LEQ, 32'd11, '0); exp_resp(c0 + 5, 32'd0, 1'b0);
    issue(LEQ, 32'd11);
    wait_resp(2);

    // NEXT_LEVEL out of the last level is an error
    cfg_clear();
    cfg(1, 0, NEXT_LEVEL, 32'd21, 4'b0001); cfg(2, 0, NEXT_LEVEL, 32'd22, 4'b0011);
    cfg(3, 0, NEXT_LEVEL, 32'd23, 4'b0101); cfg(4, 0, NEXT_LEVEL, 32'd24, 4'b1111);
    c0 = cyc;
    exp_start(c0 + 1, 1, LEQ, 32'd20, 3'd0); exp_start(c0 + 3, 2, LEQ, 32'd21, 3'd1);
    exp_start(c0 + 5, 3, LEQ, 32'd22, 3'd3); exp_start(c0 + 7, 4, LEQ, 32'd23, 3'd5);
    exp_resp(c0 + 9, 32'd0, 1'b1);
    issue(LEQ, 32'd20);
    wait_resp(2);

    // Fill to 15 entries, then LEQ must be rejected
    cfg_clear(); cfg(1, 0, DONE, 32'd0, '0);
    for (int n = 3; n <= 15; n++) begin
      c0 = cyc; exp_start(c0 + 1, 1, LEQ, 32'(100 + n), '0); exp_resp(c0 + 3, 32'd0, 1'b0);
      issue(LEQ, 32'(100 + n));
      wait_resp((LEVELS+1)'(n));
    end
    c0 = cyc; exp_resp(c0 + 1, 32'd0, 1'b1);
    issue(LEQ, 32'd999);
    wait_resp(15);

    // Reset while sampling a waiting level
    cfg_clear(); cfg(1, 5, DONE, 32'd0, '0);
    c0 = cyc; exp_start(c0 + 1, 1, DEQ, 32'd0, '0);
    issue(DEQ, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", 64'(req_ready), 64'd1);
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_rvalid", 64'(resp_valid), 64'd0);
    repeat (6) @(negedge clk);

    check("start_q_left", 64'(start_q.size()), 64'd0);
    check("resp_q_left", 64'(resp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
